add_share_arb: RTL
==================

# add_share_arb

Two-requester round-robin arbiter and sequencer for a single shared 32-bit adder datapath in the execute stage. Each requester presents operand pairs over a valid/ready handshake. The block grants one request per cycle, drives the shared `adder32` instance, and captures the sum into a one-entry response register. The register is drained by a downstream valid/ready consumer, so back-pressure stalls both requesters and never drops a result.

## Interface
Parameters:
- `TAG_W`, default 2: width of the opaque per-request tag returned with the result.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 is granted this cycle; transfer occurs when valid and ready are both high.
- `req0_a` in 32: requester 0 operand A.
- `req0_b` in 32: requester 0 operand B.
- `req0_tag` in `TAG_W`: requester 0 tag.
- `req1_valid` in 1, `req1_ready` out 1, `req1_a` in 32, `req1_b` in 32, `req1_tag` in `TAG_W`: the same signals for requester 1.
- `rsp_valid` out 1: the response register holds a result.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_sum` out 32: `(a + b) mod 2^32`.
- `rsp_src` out 1: index of the requester that produced the result.
- `rsp_tag` out `TAG_W`: the tag of that request.

## Operation
- State:
  - Response register: `rsp_valid`, `rsp_sum`, `rsp_src`, `rsp_tag`.
  - Round-robin pointer `last` (1 bit): index of the most recently granted requester.
- Slot free: `free = !rsp_valid || rsp_ready`.
  - A result that is draining this cycle frees the slot in the same cycle.
- Grant, evaluated when `free` is high:
  - Only one requester valid: that requester is granted.
  - Both valid: grant `!last`.
  - Neither valid: no grant.
  - `free` low: no grant.
- `reqN_ready` is high only for the granted requester. It is never high for a requester whose valid is low.
  - Ready is combinational from `free`, `last` and both valids.
- Shared adder: operands are muxed from the granted requester.
  - With no grant, the mux selects requester `last` and the adder output is ignored.
- On a grant edge, in one clock:
  - `rsp_valid` is set to 1.
  - `rsp_sum` takes the adder output; `rsp_src` and `rsp_tag` take the granted requester's index and tag.
  - `last` takes the granted index.
- Drain without a grant (`rsp_valid && rsp_ready` and no grant): `rsp_valid` is cleared to 0, and the sum/src/tag fields hold their values.
- Response hold: while `rsp_valid && !rsp_ready`, all response outputs hold stable.
- Arithmetic: 32-bit modular add with no carry-out. Example: `0xFFFFFFFF + 1 = 0`.
- Requester obligation: a requester whose valid is high keeps its operands and tag stable until its ready is sampled high. The block does not check this.
- Reset values, applied asynchronously while `rst_n` is low:
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_src=0`, `rsp_tag=0`.
  - `last=1`, so requester 0 wins the first contention.
  - Both readies are forced to 0.
- Reset mid-operation: a held but unconsumed response is discarded.
  - No request is granted in a cycle where `rst_n` is low.

## Timing
- Latency: request handshake at edge N; `rsp_valid` is high after edge N, with the sum valid in the same cycle.
- Throughput: one result per cycle while `rsp_ready` is held high. Under full contention, grants alternate 0,1,0,1.
- Back-pressure: with `rsp_ready` low and `rsp_valid` high, both readies are 0. On the cycle `rsp_ready` rises, a new grant is allowed in that same cycle, with no bubble.
- Starvation bound: a continuously valid requester is granted within 2 free cycles.
- Critical path: `last`/valids → operand mux → 8-slice `adder32` ripple → response register.

## Structure
- Shared execute package: `TAG_W` default and the requester-index constants `SRC_REQ0=0` and `SRC_REQ1=1`.
- One sub-module: a single instance of the existing `adder32`, fed by the operand mux.
- Grant logic, pointer and response register stay inline.

## Test plan
- Single request: after reset, `req0` sends `a=0x00000005`, `b=0x00000003`, `tag=2`, with `rsp_ready=1` → `req0_ready=1` that cycle; next cycle `rsp_valid=1`, `rsp_sum=0x00000008`, `rsp_src=0`, `rsp_tag=2`.
- Wrap-around: `req1` sends `0xFFFFFFFF + 0x00000001` → `rsp_sum=0x00000000`, `rsp_src=1`.
- Contention: both requesters continuously valid for 4 cycles with `rsp_ready=1` → grants in the order 0,1,0,1 and four consecutive responses with matching tags.
- Back-pressure: response held with `rsp_ready=0` for 3 cycles while both requesters are valid → both readies 0, response outputs stable. Raising `rsp_ready` grants the next requester in the same cycle, and the new result appears the cycle after.
- Reset mid-operation: assert `rst_n=0` while `rsp_valid=1` → `rsp_valid`, `rsp_sum`, `rsp_src` and `rsp_tag` go to 0 immediately (asynchronously) and both readies are 0. After release, the first contention grants requester 0.

Source files
------------

// File: rtl/add_share_arb_pkg.sv
// Shared execute-stage definitions for the add_share_arb block.
//   TAG_W_DEF : default width of the opaque per-request tag
//   SRC_REQ0  : requester index of requester 0
//   SRC_REQ1  : requester index of requester 1
package add_share_arb_pkg;

  localparam int TAG_W_DEF = 2;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/add_share_arb_adder32.sv
// adder32: 32-bit modular adder built as eight 4-bit ripple slices.
// Ports:
//   a, b : 32-bit operands
//   sum  : (a + b) mod 2^32, carry out of the top slice is discarded
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [7:0] carry;

  assign carry[0] = 1'b0;

  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < 7) begin : g_mid
      assign {carry[g+1], sum[4*g+3:4*g]} =
        {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]} + {4'b0000, carry[g]};
    end else begin : g_top
      // Top slice drops its carry: the add is modulo 2^32.
      assign sum[4*g+3:4*g] =
        a[4*g+3:4*g] + b[4*g+3:4*g] + {3'b000, carry[g]};
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: two-requester round-robin arbiter in front of one shared
// adder32, with a one-entry response register drained by valid/ready.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   req0_valid/ready/a/b/tag            : requester 0 handshake + operands
//   req1_valid/ready/a/b/tag            : requester 1 handshake + operands
//   rsp_valid, rsp_ready                : response handshake
//   rsp_sum, rsp_src, rsp_tag           : result, source index, request tag
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_sum,
  output logic             rsp_src,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_sum_q,   rsp_sum_d;
  logic             rsp_src_q,   rsp_src_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
  logic             last_q,      last_d;

  logic             free;
  logic             gnt;
  logic             gnt_idx;
  logic             sel;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      add_sum;

  // A draining response frees the slot in the same cycle. rst_n gates the
  // grant so nothing is accepted while reset is held.
  assign free = rst_n && (!rsp_valid_q || rsp_ready);

  always_comb begin
    gnt     = 1'b0;
    gnt_idx = last_q;
    if (free) begin
      if (req0_valid && req1_valid) begin
        gnt     = 1'b1;
        gnt_idx = !last_q;
      end else if (req0_valid) begin
        gnt     = 1'b1;
        gnt_idx = SRC_REQ0;
      end else if (req1_valid) begin
        gnt     = 1'b1;
        gnt_idx = SRC_REQ1;
      end
    end
  end

  assign req0_ready = gnt && (gnt_idx == SRC_REQ0);
  assign req1_ready = gnt && (gnt_idx == SRC_REQ1);

  // With no grant the mux parks on the last winner; the sum is unused then.
  assign sel  = gnt ? gnt_idx : last_q;
  assign op_a = (sel == SRC_REQ1) ? req1_a : req0_a;
  assign op_b = (sel == SRC_REQ1) ? req1_b : req0_b;

  adder32 u_adder32 (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_src_d   = rsp_src_q;
    rsp_tag_d   = rsp_tag_q;
    last_d      = last_q;
    if (gnt) begin
      rsp_valid_d = 1'b1;
      rsp_sum_d   = add_sum;
      rsp_src_d   = gnt_idx;
      rsp_tag_d   = (gnt_idx == SRC_REQ1) ? req1_tag : req0_tag;
      last_d      = gnt_idx;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_src_q   <= SRC_REQ0;
      rsp_tag_q   <= '0;
      last_q      <= SRC_REQ1;  // requester 0 wins the first contention
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_src_q   <= rsp_src_d;
      rsp_tag_q   <= rsp_tag_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_src   = rsp_src_q;
  assign rsp_tag   = rsp_tag_q;

endmodule
